// File: rtl/cfs_synch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cfs_synch_fifo
// Purpose  : Single-clock show-ahead FIFO with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module cfs_synch_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          clr,
   input  logic                          push_valid,
   input  logic [DATA_WIDTH-1:0]         push_data,
   output logic                          push_ready,
   output logic                          pop_valid,
   output logic [DATA_WIDTH-1:0]         pop_data,
   input  logic                          pop_ready,
   output logic [$clog2(FIFO_DEPTH):0]   usage,
   output logic                          full,
   output logic                          empty
);

   localparam int               c_AW      = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0]    c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
   localparam logic [c_AW:0]    c_CNT_ONE = (c_AW+1)'(1);
   localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]       r_wr_ptr;
   logic [c_AW-1:0]       r_rd_ptr;
   logic [c_AW:0]         r_usage;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Status flags decode only the occupancy register, never the inputs.
   assign w_full  = (r_usage == c_DEPTH);
   assign w_empty = (r_usage == '0);
   assign w_push  = push_valid & ~w_full;
   assign w_pop   = pop_ready  & ~w_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_usage  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_usage  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_usage <= r_usage + c_CNT_ONE;
            2'b01:   r_usage <= r_usage - c_CNT_ONE;
            default: r_usage <= r_usage;
         endcase
      end
   end

   // Storage carries no reset; a flushed cycle must not write.
   always_ff @(posedge clk) begin
      if (w_push && !clr) r_mem[r_wr_ptr] <= push_data;
   end

   assign push_ready = ~w_full;
   assign pop_valid  = ~w_empty;
   assign pop_data   = r_mem[r_rd_ptr];
   assign usage      = r_usage;
   assign full       = w_full;
   assign empty      = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_cfs_synch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfs_synch_fifo
// Purpose  : Directed plus randomized bench against a queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfs_synch_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clr;
   logic          push_valid;
   logic [DW-1:0] push_data;
   logic          push_ready;
   logic          pop_valid;
   logic [DW-1:0] pop_data;
   logic          pop_ready;
   logic [3:0]    usage;
   logic          full;
   logic          empty;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] q[$];

   cfs_synch_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr),
      .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
      .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
      .usage(usage), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("usage",      64'(usage),      64'(q.size()));
      chk("empty",      64'(empty),      64'(q.size() == 0));
      chk("full",       64'(full),       64'(q.size() == DEPTH));
      chk("push_ready", 64'(push_ready), 64'(q.size() != DEPTH));
      chk("pop_valid",  64'(pop_valid),  64'(q.size() != 0));
      if (q.size() != 0) chk("pop_data", 64'(pop_data), 64'(q[0]));
   endtask

   // One clock: the model consumes the inputs that were present at the edge.
   task automatic step();
      bit do_push, do_pop;
      @(posedge clk);
      do_push = push_valid && (q.size() < DEPTH);
      do_pop  = pop_ready  && (q.size() > 0);
      if (!reset_n || clr) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(push_data);
      end
      #1;
      check_all();
   endtask

   // Producer rule: a held-off offer stays stable while push_ready is low.
   logic          hold_armed = 1'b0;
   logic [DW-1:0] hold_data  = '0;
   always @(negedge clk) begin
      if (reset_n && hold_armed && !push_ready)
         chk("producer_hold", {31'd0, push_valid, push_data}, {31'd0, 1'b1, hold_data});
      hold_armed <= reset_n && push_valid && !push_ready;
      hold_data  <= push_data;
   end

   initial begin
      reset_n = 1'b0; clr = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
      step();
      step();
      chk("reset_usage", 64'(usage), 64'd0);
      chk("reset_empty", 64'(empty), 64'd1);
      chk("reset_full",  64'(full),  64'd0);
      chk("reset_pready",64'(push_ready), 64'd1);
      chk("reset_pvalid",64'(pop_valid),  64'd0);
      reset_n = 1'b1;
      step();

      // Fill with 0x11..0x88 while the consumer stalls
      for (int i = 0; i < 8; i++) begin
         push_valid = 1'b1; push_data = 32'h11 * (i + 1);
         step();
      end
      chk("fill_full",   64'(full),       64'd1);
      chk("fill_pready", 64'(push_ready), 64'd0);
      chk("fill_usage",  64'(usage),      64'd8);

      // Backpressure: 0x99 held off, one pop frees a slot
      push_data = 32'h99;
      step();
      chk("bp_held_usage", 64'(usage), 64'd8);
      pop_ready = 1'b1;
      step();
      pop_ready = 1'b0;
      chk("bp_after_pop_usage", 64'(usage), 64'd7);
      step();
      push_valid = 1'b0;
      chk("bp_accept_usage", 64'(usage), 64'd8);

      // Drain: 0x22..0x88 then 0x99
      pop_ready = 1'b1;
      for (int i = 1; i < 9; i++) begin
         chk("drain_order", 64'(pop_data), (i < 8) ? 64'(32'h11 * (i + 1)) : 64'h99);
         step();
      end
      chk("drain_empty", 64'(empty), 64'd1);
      step();
      chk("empty_ignores_pop", 64'(usage), 64'd0);
      pop_ready = 1'b0;

      // Concurrent push+pop at usage 3
      for (int i = 0; i < 3; i++) begin
         push_valid = 1'b1; push_data = $urandom; step();
      end
      pop_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_data = $urandom; step();
         chk("concurrent_usage", 64'(usage), 64'd3);
      end
      pop_ready = 1'b0;

      // Flush at usage 5 with a push offered
      for (int i = 0; i < 2; i++) begin
         push_data = $urandom; step();
      end
      chk("pre_flush_usage", 64'(usage), 64'd5);
      clr = 1'b1; push_data = 32'hDEAD_BEEF;
      step();
      clr = 1'b0;
      chk("flush_usage", 64'(usage), 64'd0);
      chk("flush_empty", 64'(empty), 64'd1);
      push_data = 32'h1234;
      step();
      push_valid = 1'b0;
      chk("flush_first_word", 64'(pop_data), 64'h1234);
      pop_ready = 1'b1; step(); pop_ready = 1'b0;

      // Async reset between edges at usage 4
      push_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_data = $urandom; step();
      end
      push_valid = 1'b0;
      chk("pre_reset_usage", 64'(usage), 64'd4);
      #2 reset_n = 1'b0;
      #1;
      chk("async_usage",  64'(usage),      64'd0);
      chk("async_empty",  64'(empty),      64'd1);
      chk("async_full",   64'(full),       64'd0);
      chk("async_pready", 64'(push_ready), 64'd1);
      chk("async_pvalid", 64'(pop_valid),  64'd0);
      step();
      reset_n = 1'b1;
      push_valid = 1'b1; push_data = 32'hA5A5_5A5A;
      step();
      push_valid = 1'b0;
      chk("post_reset_first", 64'(pop_data), 64'hA5A5_5A5A);

      // Randomized traffic, producer obeys the hold rule
      for (int i = 0; i < 600; i++) begin
         if (!(push_valid && q.size() == DEPTH)) begin
            push_valid = ($urandom_range(0, 3) != 0);
            push_data  = $urandom;
         end
         pop_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr       = ($urandom_range(0, 63) == 0);
         step();
      end
      clr = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
